// File: rtl/ahb3lite_arbiter.sv
// Two-master AHB3-Lite arbiter: round-robin with burst-boundary handover, a beat quota,
// one forced-IDLE handover cycle and parking on the last owner.
module ahb3lite_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              m0_HBUSREQ,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic [1:0]        m0_HTRANS,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [2:0]        m0_HBURST,
  input  logic              m1_HBUSREQ,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic [1:0]        m1_HTRANS,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [2:0]        m1_HBURST,
  input  logic              HREADY,
  output logic [1:0]        o_HGRANT,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTER
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  typedef enum logic {StOwn, StHandover} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [1:0]       grant_q, grant_d;
  logic             hmaster_q, hmaster_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_upd;

  logic       own_req, other_req;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       accepted, boundary, quota_hit, handover;

  // Beats still to come after a NONSEQ; INCR counts as 0 so it can be broken every beat.
  function automatic logic [3:0] burst_rem(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_rem = 4'd3;
      3'd4, 3'd5: burst_rem = 4'd7;
      3'd6, 3'd7: burst_rem = 4'd15;
      default:    burst_rem = 4'd0;
    endcase
  endfunction

  always_comb begin
    if (owner_q) begin
      own_req   = m1_HBUSREQ;
      other_req = m0_HBUSREQ;
      own_trans = m1_HTRANS;
      own_burst = m1_HBURST;
      HADDR     = m1_HADDR;
      HWRITE    = m1_HWRITE;
      HSIZE     = m1_HSIZE;
    end else begin
      own_req   = m0_HBUSREQ;
      other_req = m1_HBUSREQ;
      own_trans = m0_HTRANS;
      own_burst = m0_HBURST;
      HADDR     = m0_HADDR;
      HWRITE    = m0_HWRITE;
      HSIZE     = m0_HSIZE;
    end
  end

  // Bookkeeping for the cycle in progress; boundary and quota look at the updated values.
  always_comb begin
    HBURST = own_burst;
    HTRANS = own_trans;
    if (state_q == StHandover || (!own_req && own_trans == TrNonseq)) begin
      HTRANS = TrIdle;
    end
    accepted = HREADY && HTRANS[1];

    remaining_d = remaining_q;
    if (accepted && HTRANS == TrNonseq) begin
      remaining_d = burst_rem(own_burst);
    end else if (accepted && HTRANS == TrSeq && remaining_q != 4'd0) begin
      remaining_d = remaining_q - 4'd1;
    end

    beat_cnt_upd = beat_cnt_q;
    if (accepted && beat_cnt_q < CNT_W'(HOLD_MAX)) begin
      beat_cnt_upd = beat_cnt_q + CNT_W'(1);
    end

    boundary  = HREADY && remaining_d == 4'd0;
    quota_hit = beat_cnt_upd >= CNT_W'(HOLD_MAX);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOwn: begin
        if (boundary && other_req && (!own_req || quota_hit)) begin
          state_d = StHandover;
        end
      end
      StHandover: state_d = StOwn;
    endcase
  end

  always_comb begin
    handover   = state_q == StOwn && state_d == StHandover;
    owner_d    = handover ? ~owner_q : owner_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_upd;
    if (handover) begin
      grant_d    = owner_q ? 2'b01 : 2'b10;
      beat_cnt_d = '0;
    end
    hmaster_d = HREADY ? owner_q : hmaster_q;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= StOwn;
      owner_q     <= 1'b0;
      grant_q     <= 2'b01;
      hmaster_q   <= 1'b0;
      remaining_q <= 4'd0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign o_HGRANT = grant_q;
  assign HMASTER  = hmaster_q;

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// Bench for ahb3lite_arbiter: directed vector table, directed corner sequences, and random
// stimulus against a cycle-level reference model running alongside everything.
module tb_ahb3lite_arbiter;

  localparam int unsigned AW   = 32;
  localparam int          HOLD = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          r0, r1, w0, w1, hready;
  logic [AW-1:0] a0, a1;
  logic [1:0]    t0, t1;
  logic [2:0]    s0, s1, b0, b1;
  logic [1:0]    grant, htrans;
  logic [AW-1:0] haddr;
  logic          hwrite, hmaster;
  logic [2:0]    hsize, hburst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb3lite_arbiter #(.ADDR_W(AW), .HOLD_MAX(HOLD), .CNT_W(5)) dut (
    .HCLK(clk), .HRESETn(rstn),
    .m0_HBUSREQ(r0), .m0_HADDR(a0), .m0_HTRANS(t0), .m0_HWRITE(w0), .m0_HSIZE(s0),
    .m0_HBURST(b0),
    .m1_HBUSREQ(r1), .m1_HADDR(a1), .m1_HTRANS(t1), .m1_HWRITE(w1), .m1_HSIZE(s1),
    .m1_HBURST(b1),
    .HREADY(hready), .o_HGRANT(grant), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HMASTER(hmaster)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_own = 0, m_left = 0, m_ten = 0, m_dph = 0;
  bit m_gap = 0, mdl_on = 0;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  always @(negedge clk) begin : model
    logic          rq [2];
    logic [1:0]    tr [2];
    logic [2:0]    bu [2];
    logic [2:0]    sz [2];
    logic          wr [2];
    logic [AW-1:0] ad [2];
    logic [1:0]    eg, et;
    int            o;
    if (mdl_on) begin
      rq[0] = r0; tr[0] = t0; bu[0] = b0; sz[0] = s0; wr[0] = w0; ad[0] = a0;
      rq[1] = r1; tr[1] = t1; bu[1] = b1; sz[1] = s1; wr[1] = w1; ad[1] = a1;
      o  = m_own;
      eg = (o == 0) ? 2'b01 : 2'b10;
      et = (m_gap || (!rq[o] && tr[o] == 2'b10)) ? 2'b00 : tr[o];
      chk("model", {grant, htrans, haddr, hwrite, hsize, hburst, hmaster},
          {eg, et, ad[o], wr[o], sz[o], bu[o], m_dph[0]});
      if (!rstn) begin
        m_own = 0; m_gap = 0; m_left = 0; m_ten = 0; m_dph = 0;
      end else begin
        if (hready) m_dph = o;
        if (m_gap) begin
          m_gap = 0;
        end else begin
          if (hready && et[1]) begin
            m_ten = (m_ten < HOLD) ? m_ten + 1 : HOLD;
            if (et == 2'b10) m_left = burst_len(bu[o]) - 1;
            else if (m_left > 0) m_left--;
          end
          if (hready && m_left == 0 && rq[1-o] && (!rq[o] || m_ten >= HOLD)) begin
            m_own = 1 - o; m_gap = 1; m_ten = 0;
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic r0; logic [1:0] t0; logic [2:0] b0;
    logic r1; logic [1:0] t1; logic [2:0] b1;
    logic rdy; logic [1:0] eg; logic [1:0] et; logic ehm; logic chm;
  } vec_t;

  task automatic drv(input logic q0, input logic [1:0] x0, input logic [2:0] u0,
                     input logic q1, input logic [1:0] x1, input logic [2:0] u1,
                     input logic rdy);
    r0 = q0; t0 = x0; b0 = u0; r1 = q1; t1 = x1; b1 = u1; hready = rdy;
  endtask

  task automatic hc(input string nm, input logic [1:0] eg, input logic [1:0] et,
                    input logic ehm, input logic chm);
    @(negedge clk);
    chk({nm, ".grant"}, 64'(grant), 64'(eg));
    chk({nm, ".htrans"}, 64'(htrans), 64'(et));
    if (chm) chk({nm, ".hmaster"}, 64'(hmaster), 64'(ehm));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drv(0, 2'b00, 3'd0, 0, 2'b00, 3'd0, 1);
    nxt(); nxt();
    rstn = 1'b1;
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 2'b00, 3'd0, 0, 2'b00, 3'd0, 1, 2'b01, 2'b00, 0, 1};
    tbl[1] = '{1, 2'b10, 3'd3, 0, 2'b00, 3'd0, 1, 2'b01, 2'b10, 0, 1};
    tbl[2] = '{1, 2'b11, 3'd3, 1, 2'b10, 3'd0, 1, 2'b01, 2'b11, 0, 1};
    tbl[3] = '{1, 2'b11, 3'd3, 1, 2'b10, 3'd0, 1, 2'b01, 2'b11, 0, 1};
    tbl[4] = '{0, 2'b11, 3'd3, 1, 2'b10, 3'd0, 1, 2'b01, 2'b11, 0, 1};
    tbl[5] = '{0, 2'b00, 3'd0, 1, 2'b10, 3'd0, 1, 2'b10, 2'b00, 0, 1};
    tbl[6] = '{0, 2'b00, 3'd0, 1, 2'b10, 3'd0, 1, 2'b10, 2'b10, 0, 0};
    tbl[7] = '{0, 2'b00, 3'd0, 1, 2'b00, 3'd0, 1, 2'b10, 2'b00, 1, 1};
    tbl[8] = '{0, 2'b00, 3'd0, 0, 2'b00, 3'd0, 1, 2'b10, 2'b00, 1, 1};

    a0 = 32'h100; a1 = 32'h200; w0 = 0; w1 = 1; s0 = 3'd2; s1 = 3'd2;
    drv(0, 2'b00, 3'd0, 0, 2'b00, 3'd0, 1);
    rstn = 1'b0;
    @(posedge clk);
    mdl_on = 1;
    @(posedge clk);
    #1 rstn = 1'b1;

    // Reset and parking
    for (int i = 0; i < 3; i++) begin
      hc("park", 2'b01, 2'b00, 0, 1);
      nxt();
    end

    // Single handover from the vector table
    for (int i = 0; i < 9; i++) begin
      drv(tbl[i].r0, tbl[i].t0, tbl[i].b0, tbl[i].r1, tbl[i].t1, tbl[i].b1, tbl[i].rdy);
      hc($sformatf("vec%0d", i), tbl[i].eg, tbl[i].et, tbl[i].ehm, tbl[i].chm);
      nxt();
    end

    // Wait states inside an INCR8 with m1 requesting throughout
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drv((k != 10), (k == 0) ? 2'b10 : 2'b11, 3'd5, 1, 2'b10, 3'd0,
          !(k >= 4 && k <= 6));
      hc("wait", 2'b01, (k == 0) ? 2'b10 : 2'b11, 0, 1);
      nxt();
    end
    drv(0, 2'b00, 3'd0, 1, 2'b10, 3'd0, 1);
    hc("wait.ho", 2'b10, 2'b00, 0, 1);
    nxt();
    hc("wait.m1", 2'b10, 2'b10, 1, 1);
    nxt();

    // Quota: 16 beats of back-to-back INCR4 each way
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drv(1, (k % 4 == 0) ? 2'b10 : 2'b11, 3'd3, 1, 2'b10, 3'd3, 1);
      hc("quota0", 2'b01, (k % 4 == 0) ? 2'b10 : 2'b11, 0, 0);
      nxt();
    end
    hc("quota0.ho", 2'b10, 2'b00, 0, 1);
    nxt();
    for (int k = 0; k < 16; k++) begin
      drv(1, 2'b10, 3'd3, 1, (k % 4 == 0) ? 2'b10 : 2'b11, 3'd3, 1);
      hc("quota1", 2'b10, (k % 4 == 0) ? 2'b10 : 2'b11, 1, (k > 0));
      nxt();
    end
    hc("quota1.ho", 2'b01, 2'b00, 1, 1);
    nxt();

    // Undefined INCR preempted by quota, then resumed with NONSEQ
    drv(0, 2'b00, 3'd0, 1, 2'b10, 3'd1, 1);
    hc("incr.rel", 2'b01, 2'b00, 0, 1);
    nxt();
    hc("incr.ho", 2'b10, 2'b00, 0, 1);
    nxt();
    for (int k = 0; k < 16; k++) begin
      drv(1, 2'b10, 3'd0, 1, (k == 0) ? 2'b10 : 2'b11, 3'd1, 1);
      hc("incr", 2'b10, (k == 0) ? 2'b10 : 2'b11, 1, 1);
      nxt();
    end
    hc("incr.pre", 2'b01, 2'b00, 1, 1);
    nxt();
    drv(1, 2'b10, 3'd0, 1, 2'b10, 3'd1, 1);
    hc("incr.m0", 2'b01, 2'b10, 0, 1);
    nxt();
    drv(0, 2'b00, 3'd0, 1, 2'b10, 3'd1, 1);
    hc("incr.m0rel", 2'b01, 2'b00, 0, 1);
    nxt();
    hc("incr.ho2", 2'b10, 2'b00, 0, 1);
    nxt();
    hc("incr.resume", 2'b10, 2'b10, 1, 1);
    nxt();

    // Reset on beat 3 of an m1 WRAP8
    drv(0, 2'b00, 3'd0, 1, 2'b10, 3'd4, 1);
    hc("rst.b1", 2'b10, 2'b10, 1, 1);
    nxt();
    drv(0, 2'b00, 3'd0, 1, 2'b11, 3'd4, 1);
    hc("rst.b2", 2'b10, 2'b11, 1, 1);
    nxt();
    rstn = 1'b0;
    hc("rst.b3", 2'b10, 2'b11, 1, 1);
    nxt();
    rstn = 1'b1;
    hc("rst.after", 2'b01, 2'b00, 0, 1);
    nxt();
    hc("rst.ho", 2'b10, 2'b00, 0, 1);
    nxt();
    drv(0, 2'b00, 3'd0, 1, 2'b10, 3'd4, 1);
    hc("rst.m1", 2'b10, 2'b10, 1, 1);
    nxt();

    // Random traffic checked by the model only
    for (int n = 0; n < 3000; n++) begin
      r0 = $urandom_range(0, 3) != 0;
      r1 = $urandom_range(0, 3) != 0;
      t0 = 2'($urandom); t1 = 2'($urandom);
      b0 = 3'($urandom); b1 = 3'($urandom);
      a0 = $urandom;     a1 = $urandom;
      w0 = 1'($urandom); w1 = 1'($urandom);
      s0 = 3'($urandom); s1 = 3'($urandom);
      hready = $urandom_range(0, 3) != 0;
      rstn   = $urandom_range(0, 299) != 0;
      nxt();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
